// File: rtl/fir_sched_pkg.sv
// Shared types and default widths for the stereo FIR MAC scheduler.
package fir_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC_L = 2'd1,
    MAC_R = 2'd2,
    DONE  = 2'd3
  } fir_state_t;

  localparam int FIR_TAPS  = 8;
  localparam int FIR_DW    = 24;
  localparam int FIR_CW    = 16;
  localparam int PROD_W    = FIR_DW + FIR_CW;
  localparam int ACC_W     = PROD_W + $clog2(FIR_TAPS);
  localparam int ACC_SHIFT = FIR_CW - 1;
  localparam int DEF_COEF  = 4096;

endpackage

// File: rtl/fir_mac_unit.sv
// Shared signed multiply-accumulate unit with Q1.15 rescaling output stage.
// Build option: define FIR_SAT_EN to saturate the rescaled result instead of
// wrapping it to DW bits.
module fir_mac_unit import fir_sched_pkg::*; #(
  parameter int DW = FIR_DW,
  parameter int CW = FIR_CW,
  parameter int AW = ACC_W,
  parameter int SH = ACC_SHIFT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic signed [DW-1:0] sample,
  input  logic signed [CW-1:0] coef,
  output logic signed [DW-1:0] result
);

  localparam int PW = DW + CW;
  localparam int HW = AW - SH - DW + 1;

  logic signed [PW-1:0] product;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_next;

  // The result reflects the sum including the current product, so the
  // channel output can be captured on the same edge as the last MAC.
  assign product  = PW'(sample) * PW'(coef);
  assign acc_next = acc + AW'(product);

  // Accumulator: clear wins over enable so a channel switch starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc_next;
    end
  end

`ifdef FIR_SAT_EN
  // Clamp when the bits above the output window disagree with the sign.
  always_comb begin
    result = acc_next[SH +: DW];
    if (acc_next[AW-1:SH+DW-1] != {HW{acc_next[AW-1]}}) begin
      result = acc_next[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end
`else
  assign result = acc_next[SH +: DW];
`endif

endmodule

// File: rtl/fir_mac_scheduler.sv
// Stereo FIR engine sharing one MAC between left and right channels.
// Build option: FIR_SAT_EN (saturating output stage in fir_mac_unit).
module fir_mac_scheduler #(
  parameter int TAPS     = fir_sched_pkg::FIR_TAPS,
  parameter int DW       = fir_sched_pkg::FIR_DW,
  parameter int CW       = fir_sched_pkg::FIR_CW,
  parameter int DEF_COEF = fir_sched_pkg::DEF_COEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DW-1:0]            in_l,
  input  logic [DW-1:0]            in_r,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DW-1:0]            out_l,
  output logic [DW-1:0]            out_r,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [CW-1:0]            coef_data,
  output logic                     busy
);

  import fir_sched_pkg::*;

  localparam int IW = $clog2(TAPS);
  localparam int AW = DW + CW + IW;
  localparam int SH = CW - 1;

  fir_state_t state, next_state;

  logic [IW-1:0]        idx;
  logic                 last;
  logic                 accept;
  logic                 mac_en;
  logic                 mac_clear;
  logic signed [DW-1:0] mac_sample;
  logic signed [DW-1:0] mac_result;

  logic signed [DW-1:0] tap_l [TAPS];
  logic signed [DW-1:0] tap_r [TAPS];
  logic signed [CW-1:0] coef  [TAPS];

  assign last       = (idx == IW'(TAPS - 1));
  assign in_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign mac_sample = (state == MAC_R) ? tap_r[idx] : tap_l[idx];

  fir_mac_unit #(
    .DW (DW),
    .CW (CW),
    .AW (AW),
    .SH (SH)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (mac_clear),
    .enable (mac_en),
    .sample (mac_sample),
    .coef   (coef[idx]),
    .result (mac_result)
  );

  // Next-state and MAC control decode.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    mac_en     = 1'b0;
    mac_clear  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          mac_clear  = 1'b1;
          next_state = MAC_L;
        end
      end
      MAC_L: begin
        mac_en = 1'b1;
        if (last) begin
          mac_clear  = 1'b1;
          next_state = MAC_R;
        end
      end
      MAC_R: begin
        mac_en = 1'b1;
        if (last) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register, tap index and registered output-valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= next_state;
      out_valid <= (next_state == DONE);
      if (mac_en) begin
        idx <= last ? '0 : idx + IW'(1);
      end else begin
        idx <= '0;
      end
    end
  end

  // Delay lines shift in one stereo pair per accepted handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        tap_l[k] <= '0;
        tap_r[k] <= '0;
      end
    end else if (accept) begin
      tap_l[0] <= in_l;
      tap_r[0] <= in_r;
      for (int k = 1; k < TAPS; k++) begin
        tap_l[k] <= tap_l[k-1];
        tap_r[k] <= tap_r[k-1];
      end
    end
  end

  // Coefficient file is only writable while idle; out-of-range indices match no entry.
  for (genvar k = 0; k < TAPS; k++) begin : g_coef
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        coef[k] <= CW'(DEF_COEF);
      end else if (coef_we && (state == IDLE) && (coef_addr == IW'(k))) begin
        coef[k] <= coef_data;
      end
    end
  end

  // Capture each channel result on the final MAC edge of that channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_l <= '0;
      out_r <= '0;
    end else if (mac_en && last) begin
      if (state == MAC_L) begin
        out_l <= mac_result;
      end else begin
        out_r <= mac_result;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed scoreboard bench for fir_mac_scheduler (TAPS=8, DW=24, CW=16).
module tb_fir_mac_scheduler;

  localparam int TAPS = 8;
  localparam int DW   = 24;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] in_l = '0;
  logic [DW-1:0] in_r = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_l;
  logic [DW-1:0] out_r;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          coef_we = 1'b0;
  logic [2:0]    coef_addr = '0;
  logic [CW-1:0] coef_data = '0;
  logic          busy;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  pair_t  exp_q[$];
  longint mdl_l [TAPS];
  longint mdl_r [TAPS];
  longint mdl_coef [TAPS];

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;
  int accept_edge = 0;
  int hs_edge = 0;
  logic [DW-1:0] got_l, got_r;
  logic [DW-1:0] sat_exp;

  fir_mac_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_l      (in_l),
    .in_r      (in_r),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_l     (out_l),
    .out_r     (out_r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      mdl_l[k]    = 0;
      mdl_r[k]    = 0;
      mdl_coef[k] = 4096;
    end
  endtask

  function automatic logic [DW-1:0] model_calc(input longint taps [TAPS]);
    longint acc = 0;
    longint res;
    for (int k = 0; k < TAPS; k++) acc += taps[k] * mdl_coef[k];
    res = acc >>> (CW - 1);
`ifdef FIR_SAT_EN
    if (res > 64'sd8388607) res = 64'sd8388607;
    if (res < -64'sd8388608) res = -64'sd8388608;
`endif
    return res[DW-1:0];
  endfunction

  // Offer a pair (optionally with a coefficient write) and wait for its accept edge.
  task automatic apply_stimulus(input logic [DW-1:0] l, input logic [DW-1:0] r,
                                input logic we, input logic [2:0] addr, input logic [CW-1:0] data);
    pair_t e;
    int guard = 0;
    in_l = l; in_r = r; in_valid = 1'b1;
    coef_we = we; coef_addr = addr; coef_data = data;
    while (!in_ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", in_ready, 1'b1);
    if (we) mdl_coef[addr] = longint'($signed(data));
    for (int k = TAPS - 1; k > 0; k--) begin
      mdl_l[k] = mdl_l[k-1];
      mdl_r[k] = mdl_r[k-1];
    end
    mdl_l[0] = longint'($signed(l));
    mdl_r[0] = longint'($signed(r));
    e.l = model_calc(mdl_l);
    e.r = model_calc(mdl_r);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    accept_edge = edge_cnt;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    @(negedge clk);
  endtask

  // Wait for a filtered pair, compare against the scoreboard, then complete the handshake.
  task automatic check_output(input bit check_lat, output logic [DW-1:0] ol, output logic [DW-1:0] orr);
    pair_t e;
    int guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("out_valid_seen", out_valid, 1'b1);
    if (check_lat) check("latency", edge_cnt - accept_edge + 1, 2 * TAPS + 1);
    check("queue_has_entry", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("out_l", out_l, e.l);
      check("out_r", out_r, e.r);
    end
    ol = out_l;
    orr = out_r;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    hs_edge = edge_cnt;
    @(negedge clk);
    check("released_in_ready", in_ready, 1'b1);
    check("released_valid", out_valid, 1'b0);
  endtask

  task automatic write_coef(input logic [2:0] addr, input logic [CW-1:0] data);
    check("write_idle", in_ready, 1'b1);
    coef_we = 1'b1; coef_addr = addr; coef_data = data;
    mdl_coef[addr] = longint'($signed(data));
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  initial begin
    model_reset();

    // Reset state
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst_out_l", out_l, 24'h0);
    check("rst_out_r", out_r, 24'h0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy_after", busy, 1'b0);

    // Impulse through default coefficients
    apply_stimulus(24'h100000, 24'h0, 1'b0, 3'd0, 16'h0);
    check("busy_after_accept", busy, 1'b1);
    check_output(1'b1, got_l, got_r);
    check("impulse_1", got_l, 24'h020000);
    for (int i = 2; i <= 9; i++) begin
      apply_stimulus(24'h0, 24'h0, 1'b0, 3'd0, 16'h0);
      check_output(1'b1, got_l, got_r);
      check("impulse_n", got_l, (i <= 8) ? 24'h020000 : 24'h000000);
    end

    // Constant -8 on both channels
    for (int i = 1; i <= 8; i++) begin
      apply_stimulus(24'hFFFFF8, 24'hFFFFF8, 1'b0, 3'd0, 16'h0);
      check_output(1'b1, got_l, got_r);
    end
    check("const_l", got_l, 24'hFFFFF8);
    check("const_r", got_r, 24'hFFFFF8);

    // Coefficient write on the accept edge is used by that computation
    apply_stimulus(24'hFFFFF8, 24'hFFFFF8, 1'b1, 3'd7, 16'h0000);
    check_output(1'b1, got_l, got_r);
    check("same_edge_write", got_l, 24'hFFFFF9);

    // Output held while downstream stalls; no pair consumed
    out_ready = 1'b0;
    apply_stimulus(24'hFFFFF8, 24'hFFFFF8, 1'b0, 3'd0, 16'h0);
    for (int g = 0; g < 40 && !out_valid; g++) @(negedge clk);
    check("hold_valid", out_valid, 1'b1);
    in_l = 24'h000005; in_r = 24'h000005; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("hold_out_l", out_l, exp_q[0].l);
      check("hold_out_r", out_r, exp_q[0].r);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_out_valid", out_valid, 1'b1);
      @(negedge clk);
    end
    check_output(1'b0, got_l, got_r);
    apply_stimulus(24'h000005, 24'h000005, 1'b0, 3'd0, 16'h0);
    check("accept_gap", accept_edge - hs_edge, 1);
    check("busy_after_release", busy, 1'b1);
    check_output(1'b1, got_l, got_r);

    // Flush, then a write during MAC_L must be dropped
    for (int i = 0; i < TAPS; i++) begin
      apply_stimulus(24'h0, 24'h0, 1'b0, 3'd0, 16'h0);
      check_output(1'b1, got_l, got_r);
    end
    apply_stimulus(24'h000100, 24'h0, 1'b0, 3'd0, 16'h0);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'h7FFF;
    @(negedge clk);
    coef_we = 1'b0;
    check_output(1'b1, got_l, got_r);
    check("busy_write_dropped", got_l, 24'h000020);

    // Same write in IDLE takes effect
    for (int i = 0; i < TAPS; i++) begin
      apply_stimulus(24'h0, 24'h0, 1'b0, 3'd0, 16'h0);
      check_output(1'b1, got_l, got_r);
    end
    write_coef(3'd0, 16'h7FFF);
    apply_stimulus(24'h000100, 24'h0, 1'b0, 3'd0, 16'h0);
    check_output(1'b1, got_l, got_r);
    check("idle_write_used", got_l, 24'h0000FF);

    // Reset asserted during MAC_R
    apply_stimulus(24'h123456, 24'h654321, 1'b0, 3'd0, 16'h0);
    repeat (12) @(negedge clk);
    check("midrst_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_l", out_l, 24'h0);
    check("midrst_out_r", out_r, 24'h0);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus(24'h100000, 24'h0, 1'b0, 3'd0, 16'h0);
    check_output(1'b1, got_l, got_r);
    check("coef_restored", got_l, 24'h020000);

    // Full-scale input with maximum coefficients
    for (int k = 0; k < TAPS; k++) write_coef(3'(k), 16'h7FFF);
    for (int i = 0; i < TAPS; i++) begin
      apply_stimulus(24'h7FFFFF, 24'h7FFFFF, 1'b0, 3'd0, 16'h0);
      check_output(1'b1, got_l, got_r);
    end
`ifdef FIR_SAT_EN
    sat_exp = 24'h7FFFFF;
`else
    sat_exp = 24'hFFF7F8;
`endif
    check("fullscale_l", got_l, sat_exp);
    check("fullscale_r", got_r, sat_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
